// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: a two-entry skid buffer between ALU and memory stage,
// with branch resolution for fetch and a count of instructions handed to MEM.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_valid,
    output logic              EX_ready,
    input  logic [DATA_W-1:0] EX_alu_out,
    input  logic              EX_alu_zero,
    input  logic [DATA_W-1:0] EX_rd2,
    input  logic [REG_AW-1:0] EX_wr_reg,
    input  logic              EX_reg_write,
    input  logic              EX_mem_read,
    input  logic              EX_mem_write,
    input  logic              EX_mem_to_reg,
    input  logic              EX_branch,
    input  logic [DATA_W-1:0] EX_branch_target,
    input  logic              EX_flush,
    output logic              MEM_valid,
    input  logic              MEM_ready,
    output logic [DATA_W-1:0] MEM_alu_out,
    output logic [DATA_W-1:0] MEM_rd2,
    output logic [DATA_W-1:0] MEM_branch_target,
    output logic              MEM_alu_zero,
    output logic              MEM_reg_write,
    output logic              MEM_mem_read,
    output logic              MEM_mem_write,
    output logic              MEM_mem_to_reg,
    output logic              MEM_branch,
    output logic [REG_AW-1:0] MEM_wr_reg,
    output logic              MEM_pc_src,
    output logic [CNT_W-1:0]  MEM_xfer_count
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_out;
        logic              alu_zero;
        logic [DATA_W-1:0] rd2;
        logic [REG_AW-1:0] wr_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic [DATA_W-1:0] branch_target;
    } payload_t;

    payload_t             in_pl;
    payload_t             main_pl;
    payload_t             skid_pl;
    logic                 main_vld;
    logic                 skid_vld;
    logic [CNT_W-1:0]     xfer_cnt;
    logic                 in_fire;
    logic                 out_fire;

    assign in_pl = '{
        alu_out:       EX_alu_out,
        alu_zero:      EX_alu_zero,
        rd2:           EX_rd2,
        wr_reg:        EX_wr_reg,
        reg_write:     EX_reg_write,
        mem_read:      EX_mem_read,
        mem_write:     EX_mem_write,
        mem_to_reg:    EX_mem_to_reg,
        branch:        EX_branch,
        branch_target: EX_branch_target
    };

    // Ready comes straight from the skid valid flop, so a MEM stall never reaches EX combinationally.
    assign EX_ready = ~skid_vld;
    assign in_fire  = EX_valid & EX_ready;
    assign out_fire = main_vld & MEM_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_pl  <= '0;
            skid_pl  <= '0;
            xfer_cnt <= '0;
        end else begin
            if (out_fire) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            // Flush kills everything held and arriving; a departing entry has already left.
            if (EX_flush) begin
                main_vld <= 1'b0;
                skid_vld <= 1'b0;
            end else if (!main_vld || out_fire) begin
                if (skid_vld) begin
                    main_pl  <= skid_pl;
                    main_vld <= 1'b1;
                    skid_vld <= 1'b0;
                end else if (in_fire) begin
                    main_pl  <= in_pl;
                    main_vld <= 1'b1;
                end else begin
                    main_vld <= 1'b0;
                end
            end else if (in_fire) begin
                skid_pl  <= in_pl;
                skid_vld <= 1'b1;
            end
        end
    end

    assign MEM_valid         = main_vld;
    assign MEM_alu_out       = main_pl.alu_out;
    assign MEM_alu_zero      = main_pl.alu_zero;
    assign MEM_rd2           = main_pl.rd2;
    assign MEM_wr_reg        = main_pl.wr_reg;
    assign MEM_reg_write     = main_pl.reg_write;
    assign MEM_mem_read      = main_pl.mem_read;
    assign MEM_mem_write     = main_pl.mem_write;
    assign MEM_mem_to_reg    = main_pl.mem_to_reg;
    assign MEM_branch        = main_pl.branch;
    assign MEM_branch_target = main_pl.branch_target;
    assign MEM_pc_src        = main_vld & main_pl.branch & main_pl.alu_zero;
    assign MEM_xfer_count    = xfer_cnt;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline boundary between the execute stage (ALU) and the memory stage.
- Captures the ALU result and zero flag, store data, destination register, memory/write-back controls and branch target.
- Uses valid/ready handshakes on both sides with a 2-entry skid buffer, so `EX_ready` is a registered signal and a `MEM_ready` stall never creates a combinational path back into EX.
- Also resolves branches for fetch and counts instructions handed to MEM.

Parameters:
- DATA_W, 32, width of ALU result, store data and branch target.
- REG_AW, 5, register-file address width.
- CNT_W, 32, width of the transfer counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- EX_valid  input  1  EX presents an instruction.
- EX_ready  output  1  stage accepts the instruction this cycle (registered).
- EX_alu_out  input  DATA_W  ALU result.
- EX_alu_zero  input  1  ALU zero flag.
- EX_rd2  input  DATA_W  store data.
- EX_wr_reg  input  REG_AW  destination register.
- EX_reg_write, EX_mem_read, EX_mem_write, EX_mem_to_reg, EX_branch  input  1 each  control bits.
- EX_branch_target  input  DATA_W  computed branch address.
- EX_flush  input  1  kill all held and incoming instructions.
- MEM_valid  output  1  output entry valid.
- MEM_ready  input  1  MEM consumes the output entry.
- MEM_alu_out, MEM_rd2, MEM_branch_target  output  DATA_W  registered copies.
- MEM_alu_zero, MEM_reg_write, MEM_mem_read, MEM_mem_write, MEM_mem_to_reg, MEM_branch  output  1 each  registered copies.
- MEM_wr_reg  output  REG_AW  registered copy.
- MEM_pc_src  output  1  taken branch; equals MEM_valid & MEM_branch & MEM_alu_zero.
- MEM_xfer_count  output  CNT_W  number of completed MEM transfers.

Behaviour:
- Clock and reset: one clock (`clk`); `rst` is asynchronous and active-high.
- Reset values:
  - All outputs 0, including `MEM_valid`, `MEM_pc_src` and `MEM_xfer_count`.
  - Skid entry empty, so `EX_ready` = 1.
  - `rst` asserted mid-operation discards both entries immediately, without waiting for a clock edge.
- Storage:
  - Main entry drives the `MEM_*` outputs.
  - Skid entry is the same payload plus a valid bit.
  - `EX_ready` = !skid_valid, taken from a flop.
- Definitions: in_fire = EX_valid & EX_ready; out_fire = MEM_valid & MEM_ready.
- Per rising edge, no flush:
  - Main empty or out_fire, skid valid: main <- skid, skid empties.
  - Main empty or out_fire, skid empty, in_fire: main <- input.
  - Main empty or out_fire, neither of the above: main empties.
  - Main full and no out_fire: if in_fire, skid <- input.
  - in_fire and skid-valid cannot coincide, because `EX_ready` is low whenever skid is valid.
- Latency and throughput:
  - One cycle from in_fire to `MEM_valid`.
  - One transfer per cycle at full throughput.
  - With `MEM_ready` stuck low, exactly two instructions are held, then `EX_ready` drops.
- Flush (priority over all loads):
  - At the edge, main_valid and skid_valid are cleared.
  - An in_fire in the same cycle is dropped, even though `EX_ready` was high.
  - An out_fire in the same cycle still completes and is counted.
  - Payload flops may hold stale values; consumers qualify every output with `MEM_valid`.
- `MEM_pc_src` is purely combinational from main-entry flops. It is 0 whenever `MEM_valid` = 0.
- `MEM_xfer_count` increments by 1 on every out_fire and wraps modulo 2^CNT_W.
- Bubbles (`EX_valid` = 0) never load payload and never change the count.

Test Plan:
- Streaming: `MEM_ready` = 1, 4 back-to-back EX instructions with alu_out 0x10, 0x20, 0x30, 0x40 -> MEM_valid on cycles 1–4 with the same values in order; EX_ready stays 1; count = 4.
- Stall: `MEM_ready` = 0, 3 instructions offered (A, B, C) -> A on the MEM outputs; B in skid; EX_ready = 0 from cycle 2 with C held upstream. Raise MEM_ready -> A, B, C delivered in order with no loss or duplication.
- Branch: instruction with EX_branch = 1, EX_alu_zero = 1, target 0x0040_0100 -> next cycle MEM_pc_src = 1, MEM_branch_target = 0x0040_0100. Repeating with zero = 0 -> MEM_pc_src = 0.
- Flush: main and skid full, EX_flush pulsed while MEM_ready = 0 -> next cycle MEM_valid = 0, EX_ready = 1, count unchanged. Repeating with MEM_ready = 1 -> count += 1.
- Reset mid-stall: rst asserted asynchronously between clock edges with both entries full -> MEM_valid, MEM_pc_src and MEM_xfer_count go to 0 immediately and EX_ready goes to 1.
- Counter wrap: CNT_W = 4, 17 transfers -> MEM_xfer_count = 1.
